// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer that drives the shared EX-stage ALU with ADD
// commands to form the low WIDTH bits of op_a*op_b. Optional MLA accumulate via `ALU_MUL_SEQ_MLA_EN.
module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             set_flags,
    input  logic [3:0]       flags_in,
    output logic [3:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic             alu_c,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       sr_out,
    output logic             sr_we
`ifdef ALU_MUL_SEQ_MLA_EN
    ,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             mla
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_ADD = 4'b0010;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               sf_q, sf_d;
    logic [WIDTH-1:0]   acc_init;
    logic               last_iter;

`ifdef ALU_MUL_SEQ_MLA_EN
    assign acc_init = mla ? acc_in : '0;
`else
    assign acc_init = '0;
`endif

    // Finish once no multiplier bits remain above the one consumed this cycle.
    assign last_iter = (mplr_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sf_q     <= sf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sf_d     = sf_q;
        alu_cmd  = CMD_NOP;
        alu_val1 = '0;
        alu_val2 = '0;
        stall    = 1'b0;
        done     = 1'b0;
        sr_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall = start;
                if (start) begin
                    acc_d   = acc_init;
                    mcand_d = op_a;
                    mplr_d  = op_b;
                    cnt_d   = '0;
                    sf_d    = set_flags;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                stall    = 1'b1;
                alu_cmd  = CMD_ADD;
                alu_val1 = acc_q;
                alu_val2 = mplr_q[0] ? mcand_q : '0;
                acc_d    = alu_out;
                mcand_d  = mcand_q << 1;
                mplr_d   = mplr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = alu_out;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                sr_we   = sf_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Z and N come from the product; C and V pass through untouched.
    assign sr_out = {(acc_q == '0), flags_in[2], acc_q[WIDTH-1], flags_in[0]};
    assign alu_c  = 1'b0;
    assign busy   = (state_q != S_IDLE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised self-checking bench for alu_mul_seq against an arithmetic reference model.
// Build with +define+ALU_MUL_SEQ_MLA_EN to also exercise the multiply-accumulate ports.
module tb_alu_mul_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         set_flags;
    logic [3:0]   flags_in;
    logic [3:0]   alu_cmd;
    logic [W-1:0] alu_val1, alu_val2;
    logic         alu_c;
    logic [W-1:0] alu_out;
    logic         busy, stall, done, sr_we;
    logic [W-1:0] result;
    logic [3:0]   sr_out;
    logic [W-1:0] acc_in;
    logic         mla;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Shared ALU: only ADD is used by the sequencer.
    always_comb begin
        alu_out = '0;
        if (alu_cmd == 4'b0010) alu_out = alu_val1 + alu_val2 + {{(W-1){1'b0}}, alu_c};
    end

    alu_mul_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .set_flags(set_flags), .flags_in(flags_in), .alu_cmd(alu_cmd),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c(alu_c), .alu_out(alu_out),
        .busy(busy), .stall(stall), .done(done), .result(result),
        .sr_out(sr_out), .sr_we(sr_we)
`ifdef ALU_MUL_SEQ_MLA_EN
        , .acc_in(acc_in), .mla(mla)
`endif
    );

    function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic m, input logic [W-1:0] ai);
        logic [W-1:0] p;
        p = a * b;
        if (m) p = p + ai;
        return p;
    endfunction

    function automatic int model_iters(input logic [W-1:0] b);
        int n = 0;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [3:0] model_sr(input logic [W-1:0] p, input logic [3:0] f);
        return {(p == '0), f[2], p[W-1], f[0]};
    endfunction

    // Runs one operation and gathers observations; comparisons are made by the callers.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sf,
                          input logic [3:0] fl, input logic m, input logic [W-1:0] ai,
                          input bit chaos,
                          output int lat, output int stall_cnt, output bit timeout,
                          output bit early_we, output logic [W-1:0] res, output logic [3:0] sr,
                          output logic we, output logic busy_d, output logic stall_d,
                          output logic busy_after, output logic done_after,
                          output logic [W-1:0] res_after);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; set_flags = sf; flags_in = fl; mla = m; acc_in = ai;
        stall_cnt = 0; early_we = 1'b0;
        #1;
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        lat = 1;
        start = chaos;
        if (chaos) begin
            op_a = $urandom; op_b = $urandom; set_flags = ~sf; mla = ~m; acc_in = $urandom;
        end
        while (!done && lat < 40) begin
            if (stall) stall_cnt++;
            if (sr_we) early_we = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        timeout = !done;
        res = result; sr = sr_out; we = sr_we; busy_d = busy; stall_d = stall;
        @(posedge clk); #1;
        busy_after = busy; done_after = done; res_after = result;
        start = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sf, input logic [3:0] fl, input logic m,
                            input logic [W-1:0] ai, input bit chaos);
        int lat, sc; bit to, ew;
        logic [W-1:0] res, res_after, exp_p;
        logic [3:0] sr;
        logic we, bd, sd, ba, da;
        do_mul(a, b, sf, fl, m, ai, chaos, lat, sc, to, ew, res, sr, we, bd, sd, ba, da, res_after);
        exp_p = model_prod(a, b, m, ai);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen within 40 cycles", nm);
        end
        tests_run++;
        if (lat !== model_iters(b) + 1) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, model_iters(b) + 1);
        end
        tests_run++;
        if (res !== exp_p) begin
            tests_failed++;
            $display("FAIL %s result: got %h expected %h", nm, res, exp_p);
        end
        tests_run++;
        if (sr !== model_sr(exp_p, fl)) begin
            tests_failed++;
            $display("FAIL %s sr_out: got %b expected %b", nm, sr, model_sr(exp_p, fl));
        end
        tests_run++;
        if (we !== sf || ew) begin
            tests_failed++;
            $display("FAIL %s sr_we: got %b (early %0d) expected %b", nm, we, ew, sf);
        end
        tests_run++;
        if (sc !== model_iters(b) + 1) begin
            tests_failed++;
            $display("FAIL %s stall cycles: got %0d expected %0d", nm, sc, model_iters(b) + 1);
        end
        tests_run++;
        if (bd !== 1'b1 || sd !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done-cycle busy/stall: got %b/%b expected 1/0", nm, bd, sd);
        end
        tests_run++;
        if (ba !== 1'b0 || da !== 1'b0 || res_after !== exp_p) begin
            tests_failed++;
            $display("FAIL %s after done: busy %b done %b result %h expected 0 0 %h",
                     nm, ba, da, res_after, exp_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; set_flags = 1'b0;
        flags_in = 4'b0; mla = 1'b0; acc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || sr_we !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset ctrl: busy %b done %b sr_we %b stall %b expected 0000",
                     busy, done, sr_we, stall);
        end
        tests_run++;
        if (result !== '0 || alu_cmd !== 4'b0 || alu_val1 !== '0 || alu_val2 !== '0 || alu_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset data: result %h cmd %b v1 %h v2 %h c %b expected zeros",
                     result, alu_cmd, alu_val1, alu_val2, alu_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op("mul_7x6",      32'd7,          32'd6,          1'b1, 4'b0101, 1'b0, '0, 1'b0);
        check_op("mul_max",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 4'b0000, 1'b0, '0, 1'b0);
        check_op("mul_wrap_z",   32'h0001_0000,  32'h0001_0000,  1'b1, 4'b0010, 1'b0, '0, 1'b0);
        check_op("mul_b_zero",   32'h0000_1234,  32'd0,          1'b0, 4'b1111, 1'b0, '0, 1'b0);
        check_op("mul_neg",      32'hFFFF_FFFF,  32'd3,          1'b1, 4'b1010, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, W - 1);
            check_op("rand", a, b, 1'($urandom), 4'($urandom), 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        check_op("ign_start_long",  32'h89AB_CDEF, 32'h0000_F00D, 1'b1, 4'b0100, 1'b0, '0, 1'b1);
        check_op("ign_start_short", 32'd11,        32'd1,         1'b0, 4'b0001, 1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            check_op("b2b", $urandom, $urandom_range(1, 255), 1'b1, 4'($urandom), 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_reset_midop();
        bit seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; set_flags = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || sr_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midop: busy %b done %b sr_we %b result %h expected 0 0 0 0",
                     busy, done, sr_we, result);
        end
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || sr_we || busy) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done) begin
            tests_failed++;
            $display("FAIL reset_abandon: activity seen after reset, expected none");
        end
    endtask

`ifdef ALU_MUL_SEQ_MLA_EN
    task automatic test_mla();
        check_op("mla_on",  32'd3, 32'd5, 1'b1, 4'b0000, 1'b1, 32'd100, 1'b0);
        check_op("mla_off", 32'd3, 32'd5, 1'b1, 4'b0000, 1'b0, 32'd100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_op("mla_rand", $urandom, $urandom >> $urandom_range(0, 31), 1'b1,
                     4'($urandom), 1'b1, $urandom, 1'b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
`ifdef ALU_MUL_SEQ_MLA_EN
        test_mla();
`endif
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
